// File: rtl/fetch_unit.sv
// Instruction fetch front end: drives the icache request, buffers returned words
// in a small in-order queue and hands them to decode over a valid/ready handshake.
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int          QDEPTH  = 2
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        iREN,
    output logic [31:0] imemaddr,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_npc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        halted
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [31:0]      fetch_pc_reg, fetch_pc_next;
    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [CNT_W-1:0] count_reg, count_next;

    logic fetch_en;
    logic accept;
    logic pop;
    logic flush;
    logic q_full;
    logic q_empty;

    logic [31:0] q_instr [QDEPTH];
    logic [31:0] q_pc    [QDEPTH];

    // The two low bits of a redirect target are dropped to keep fetch word aligned.
    logic unused_bits;
    assign unused_bits = &{1'b0, redirect_pc[1:0]};

    // ------------------------------------------------------------------
    // Control FSM: START holds fetch off for one cycle after reset so a
    // stale ihit from an abandoned request can never be accepted.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= ST_START;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_START: state_next = halt ? ST_HALT : ST_RUN;
            ST_RUN:   state_next = halt ? ST_HALT : ST_RUN;
            ST_HALT:  state_next = ST_HALT;
            default:  state_next = ST_START;
        endcase
    end

    always_comb begin
        fetch_en = 1'b0;
        halted   = 1'b0;
        case (state_reg)
            ST_RUN:  fetch_en = 1'b1;
            ST_HALT: halted   = 1'b1;
            default: begin
                fetch_en = 1'b0;
                halted   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    assign q_full  = (count_reg == CNT_W'(QDEPTH));
    assign q_empty = (count_reg == '0);

    assign iREN       = fetch_en && !redirect && !halt && !q_full;
    assign accept     = iREN && ihit;
    assign inst_valid = !q_empty && !halted;
    assign pop        = inst_valid && inst_ready;

    // Halt always flushes; a redirect only matters while still running.
    assign flush = halt || (redirect && !halted);

    // ------------------------------------------------------------------
    // Fetch PC and queue pointers
    // ------------------------------------------------------------------
    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        head_next     = head_reg;
        tail_next     = tail_reg;
        count_next    = count_reg;
        if (flush) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
            if (!halt && !halted) begin
                fetch_pc_next = {redirect_pc[31:2], 2'b00};
            end
        end else begin
            if (accept) begin
                tail_next     = tail_reg + PTR_W'(1);
                fetch_pc_next = fetch_pc_reg + 32'd4;
            end
            if (pop) begin
                head_next = head_reg + PTR_W'(1);
            end
            case ({accept, pop})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetch_pc_reg <= PC_INIT;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            count_reg    <= count_next;
        end
    end

    // ------------------------------------------------------------------
    // Queue storage: payload needs no reset, occupancy is tracked by count.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_entry
        logic [31:0] instr_reg;
        logic [31:0] pc_reg;
        logic        wr_en;

        assign wr_en = accept && (tail_reg == PTR_W'(gi));

        always_ff @(posedge CLK) begin
            if (wr_en) begin
                instr_reg <= imemload;
                pc_reg    <= fetch_pc_reg;
            end
        end

        assign q_instr[gi] = instr_reg;
        assign q_pc[gi]    = pc_reg;
    end

    // ------------------------------------------------------------------
    // Outputs: an empty queue presents a NOP at PC 0.
    // ------------------------------------------------------------------
    assign imemaddr    = fetch_pc_reg;
    assign instruction = inst_valid ? q_instr[head_reg] : 32'h0000_0000;
    assign inst_pc     = inst_valid ? q_pc[head_reg]    : 32'h0000_0000;
    assign inst_npc    = inst_pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed and random steps checked against a queue-based
// reference model; a second instance covers the PC wrap at the top of memory.
module tb_fetch_unit;

    localparam int          QDEPTH = 2;
    localparam logic [31:0] INIT_A = 32'h0000_0000;
    localparam logic [31:0] INIT_B = 32'hFFFF_FFF8;

    logic        CLK;
    logic        RST;
    logic        ihit;
    logic [31:0] imemload;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;

    logic        iren_o   [2];
    logic [31:0] addr_o   [2];
    logic [31:0] instr_o  [2];
    logic [31:0] ipc_o    [2];
    logic [31:0] inpc_o   [2];
    logic        valid_o  [2];
    logic        halted_o [2];

    int sel;
    int errors;
    int checks;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq [$];
    logic [31:0] m_pc;
    logic [31:0] m_init;
    bit          m_halted;
    bit          m_started;

    fetch_unit #(.PC_INIT(INIT_A), .QDEPTH(QDEPTH)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iren_o[0]), .imemaddr(addr_o[0]),
        .ihit(ihit), .imemload(imemload),
        .instruction(instr_o[0]), .inst_pc(ipc_o[0]), .inst_npc(inpc_o[0]),
        .inst_valid(valid_o[0]), .inst_ready(inst_ready),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .halt(halt), .halted(halted_o[0])
    );

    fetch_unit #(.PC_INIT(INIT_B), .QDEPTH(QDEPTH)) dut_w (
        .CLK(CLK), .RST(RST),
        .iREN(iren_o[1]), .imemaddr(addr_o[1]),
        .ihit(ihit), .imemload(imemload),
        .instruction(instr_o[1]), .inst_pc(ipc_o[1]), .inst_npc(inpc_o[1]),
        .inst_valid(valid_o[1]), .inst_ready(inst_ready),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .halt(halt), .halted(halted_o[1])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_iren"},   32'(iren_o[sel]),   32'd0);
        chk({tag, "_valid"},  32'(valid_o[sel]),  32'd0);
        chk({tag, "_instr"},  instr_o[sel],       32'd0);
        chk({tag, "_pc"},     ipc_o[sel],         32'd0);
        chk({tag, "_npc"},    inpc_o[sel],        32'd4);
        chk({tag, "_addr"},   addr_o[sel],        m_init);
        chk({tag, "_halted"}, 32'(halted_o[sel]), 32'd0);
        $display("txn reset   inst=%0d addr=%h", sel, addr_o[sel]);
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc      = m_init;
        m_halted  = 0;
        m_started = 0;
    endtask

    // Called at a falling edge; holds RST across one rising edge.
    task automatic do_reset();
        RST = 1'b1;
        ihit = 0; imemload = '0; inst_ready = 0;
        redirect = 0; redirect_pc = '0; halt = 0;
        #1;
        reset_checks("rst");
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
    endtask

    // One clock of stimulus; outputs checked before the edge, model advanced at it.
    task automatic step(input bit h, input logic [31:0] ld, input bit rdy,
                        input bit rd, input logic [31:0] rpc, input bit hl);
        bit          e_iren;
        bit          e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
        ihit = h; imemload = ld; inst_ready = rdy;
        redirect = rd; redirect_pc = rpc; halt = hl;
        #1;
        e_iren  = m_started && !m_halted && !rd && !hl && (mq.size() < QDEPTH);
        e_valid = (mq.size() > 0);
        e_instr = e_valid ? mq[0].instr : 32'd0;
        e_ipc   = e_valid ? mq[0].pc    : 32'd0;
        chk("iREN",        32'(iren_o[sel]),   32'(e_iren));
        chk("imemaddr",    addr_o[sel],        m_pc);
        chk("inst_valid",  32'(valid_o[sel]),  32'(e_valid));
        chk("instruction", instr_o[sel],       e_instr);
        chk("inst_pc",     ipc_o[sel],         e_ipc);
        chk("inst_npc",    inpc_o[sel],        e_ipc + 32'd4);
        chk("halted",      32'(halted_o[sel]), 32'(m_halted));
        $display("txn step    ihit=%0d rdy=%0d redir=%0d halt=%0d addr=%h valid=%0d instr=%h pc=%h",
                 h, rdy, rd, hl, addr_o[sel], valid_o[sel], instr_o[sel], ipc_o[sel]);
        @(posedge CLK);
        if (!m_halted) begin
            if (hl) begin
                m_halted = 1;
                mq.delete();
            end else if (rd) begin
                mq.delete();
                m_pc = {rpc[31:2], 2'b00};
            end else begin
                if (e_valid && rdy) void'(mq.pop_front());
                if (e_iren && h) begin
                    mq.push_back('{instr: ld, pc: m_pc});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        m_started = 1;
        @(negedge CLK);
    endtask

    initial begin
        errors = 0; checks = 0; sel = 0;
        m_init = INIT_A;
        RST = 1'b1;
        ihit = 0; imemload = '0; inst_ready = 0;
        redirect = 0; redirect_pc = '0; halt = 0;
        model_reset();
        @(negedge CLK);
        do_reset();

        // Streaming fetch with decode always ready
        step(0, 32'h0, 1, 0, 32'h0, 0);
        for (int k = 0; k < 6; k++) step(1, 32'h2000_0001 + k, 1, 0, 32'h0, 0);

        // Back-pressure: queue fills, fetch stalls, one pop reopens it
        for (int k = 0; k < 4; k++) step(1, 32'h3000_0000 + k, 0, 0, 32'h0, 0);
        step(0, 32'h0, 1, 0, 32'h0, 0);
        for (int k = 0; k < 2; k++) step(1, 32'h3100_0000 + k, 0, 0, 32'h0, 0);
        for (int k = 0; k < 4; k++) step(0, 32'h0, 1, 0, 32'h0, 0);

        // Redirect with a simultaneous hit: the hit is dropped
        step(1, 32'hDEAD_0000, 1, 1, 32'h0000_0103, 0);
        chk("redir_addr",  addr_o[sel],       32'h0000_0100);
        chk("redir_valid", 32'(valid_o[sel]), 32'd0);
        for (int k = 0; k < 4; k++) step(1, 32'h4000_0000 + k, 1, 0, 32'h0, 0);

        // Back-to-back redirects: the second target wins
        step(1, 32'h0, 1, 1, 32'h0000_0200, 0);
        step(1, 32'h0, 1, 1, 32'h0000_0302, 0);
        chk("redir2_addr", addr_o[sel], 32'h0000_0300);
        for (int k = 0; k < 3; k++) step(1, 32'h4100_0000 + k, 1, 0, 32'h0, 0);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 19) == 0, $urandom, 0);
        end

        // Async reset while a request is pending and one word is queued
        do_reset();
        step(1, 32'h5500_0000, 1, 0, 32'h0, 0);
        step(1, 32'h6600_0000, 0, 0, 32'h0, 0);
        ihit = 0; inst_ready = 0;
        #1;
        chk("pre_rst_iren",  32'(iren_o[sel]),  32'd1);
        chk("pre_rst_valid", 32'(valid_o[sel]), 32'd1);
        #2;
        RST = 1'b1;
        #1;
        reset_checks("async_rst");
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        step(1, 32'h7700_0000, 1, 0, 32'h0, 0);
        for (int k = 0; k < 3; k++) step(1, 32'h7800_0000 + k, 1, 0, 32'h0, 0);

        // Halt with a simultaneous redirect: halt wins and sticks
        step(1, 32'h0, 1, 1, 32'h0000_0500, 1);
        chk("halt_flag", 32'(halted_o[sel]), 32'd1);
        for (int k = 0; k < 8; k++) begin
            step(k[0], 32'h8800_0000 + k, 1, k == 3, 32'h0000_0700, 0);
        end

        // PC wrap at the top of the address space, second instance
        sel = 1;
        m_init = INIT_B;
        do_reset();
        step(0, 32'h0, 0, 0, 32'h0, 0);
        step(1, 32'h9000_0000, 0, 0, 32'h0, 0);
        step(1, 32'h9000_0001, 0, 0, 32'h0, 0);
        chk("wrap_pc0", ipc_o[sel],  32'hFFFF_FFF8);
        chk("wrap_npc", inpc_o[sel], 32'hFFFF_FFFC);
        chk("wrap_addr", addr_o[sel], 32'h0000_0000);
        step(0, 32'h0, 1, 0, 32'h0, 0);
        chk("wrap_pc1", ipc_o[sel], 32'hFFFF_FFFC);
        for (int k = 0; k < 4; k++) step(1, 32'h9100_0000 + k, 1, 0, 32'h0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-supply side of the decode interface: fetches words from the instruction cache and presents them to the control unit's instruction input.
- Holds the fetch PC and a small in-order instruction queue.
- Uses a valid/ready handshake toward decode.
- Applies PC redirects (branch/jump/JR targets) and halt decisions that come back from decode/execute.

Parameters:
PC_INIT, 32'h0000_0000, fetch PC value after reset
QDEPTH, 2, instruction queue entries (power of two, >= 2)

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  asynchronous active-high reset
iREN  output  1  instruction read request to icache
imemaddr  output  32  instruction fetch address (word aligned)
ihit  input  1  icache returns valid imemload this cycle
imemload  input  32  fetched instruction word
instruction  output  32  queue-head instruction to control unit
inst_pc  output  32  PC of queue-head instruction
inst_npc  output  32  inst_pc + 4
inst_valid  output  1  queue head valid
inst_ready  input  1  decode accepts head this cycle
redirect  input  1  flush and restart fetch at redirect_pc
redirect_pc  input  32  new fetch target
halt  input  1  decode has accepted a halt instruction
halted  output  1  fetch permanently stopped

Behaviour:
- Reset (async, RST=1):
  - fetch_pc=PC_INIT; queue empty (head=tail=count=0); halted=0.
  - Outputs: iREN=0, inst_valid=0, instruction=0, inst_pc=0, inst_npc=4, imemaddr=PC_INIT.
- Fetch:
  - imemaddr=fetch_pc at all times.
  - iREN = !halted && !redirect && !halt && (count < QDEPTH).
  - While iREN=1 without ihit, imemaddr stays stable.
  - ihit is honoured only when iREN=1; ihit with iREN=0 is ignored.
  - On ihit && iREN: push {imemload, fetch_pc} at tail; fetch_pc += 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- Latency: ihit in cycle N gives inst_valid=1 with that word in cycle N+1 if the queue was empty. There is no combinational bypass from imemload to instruction.
- Output: instruction/inst_pc come from the head entry. When count=0, instruction=0 (a NOP) and inst_valid=0.
- Pop: inst_valid && inst_ready consumes the head. Push and pop in the same cycle: count is unchanged, both pointers advance, order is preserved.
- Full: count==QDEPTH forces iREN=0. A pop in that cycle re-enables iREN the following cycle.
- Redirect (redirect=1, halt=0):
  - Next edge: queue flushed (count=0); fetch_pc = {redirect_pc[31:2], 2'b00}.
  - Any ihit or pop in the same cycle is discarded.
  - inst_valid=0 the next cycle; the first target word appears at the earliest 2 cycles after redirect.
  - Back-to-back redirects: the last one wins.
- Halt:
  - Next edge: halted=1 and queue flushed.
  - From then on: iREN=0, inst_valid=0, instruction=0.
  - fetch_pc is frozen. halted is sticky until RST.
  - halt and redirect in the same cycle: halt wins and redirect is ignored.
- Reset mid-transaction: an in-flight request is abandoned. An ihit in the first cycle after reset deassertion is ignored because iREN is registered-qualified.
- Pointer wrap: head/tail are log2(QDEPTH) bits and wrap naturally. count is log2(QDEPTH)+1 bits.

Test Plan:
- Reset, then ihit every cycle with imemload=0x2000_0001+k and inst_ready=1 -> imemaddr 0,4,8,...; instruction 0x2000_0001 with inst_pc=0 appears one cycle after the first ihit; inst_npc=4.
- inst_ready=0 with ihit=1 -> after two accepted words count=2 and iREN=0; imemaddr holds 0x8. One cycle of inst_ready=1 -> iREN=1 the next cycle; order is preserved.
- redirect=1, redirect_pc=0x0000_0103, ihit=1 in the same cycle -> the hit word is dropped, queue is empty, imemaddr=0x100 next cycle; the next valid instruction has inst_pc=0x100.
- halt=1 and redirect=1 together -> halted=1, iREN=0, inst_valid=0 forever; imemaddr frozen; an ihit pulse is ignored.
- PC_INIT=0xFFFF_FFF8, two hits -> inst_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, then imemaddr=0x0.
- RST asserted while iREN=1 and queue holds 1 entry -> outputs return to reset values immediately (async); after release, imemaddr=PC_INIT.
